multi_byte_alu_ctrl: RTL and testbench
======================================

// Module: multi_byte_alu_ctrl
// PURPOSE
//  Initiator for the 8-bit ALU: runs NBYTES-wide ADD/SUB/EQL as a sequence of byte ops, LSB first.
//  ADD and SUB chain the carry or borrow through the ALU's OverflowIn/OverflowOut.
//  Sits between the datapath control and the single shared ALU instance; the ALU stays combinational.
// PARAMETERS
//  NBYTES  4  operand width in bytes; must be >= 1. Byte-index counter is $clog2(NBYTES+1) bits.
// PORTS
//  Clk        in   1          single clock, rising edge
//  Reset      in   1          asynchronous, active-high
//  Start      in   1          request; sampled only in IDLE
//  Cmd        in   2          00 ADD, 01 SUB, 10 EQL, 11 reserved
//  CarryIn    in   1          carry/borrow into byte 0 (ADD/SUB only)
//  OperandA   in   8*NBYTES   latched on accepted Start
//  OperandB   in   8*NBYTES   latched on accepted Start
//  Busy       out  1          high in RUN
//  Done       out  1          one-cycle completion pulse
//  Error      out  1          valid with Done; 1 = reserved Cmd
//  Result     out  8*NBYTES   held from Done until next accepted Start
//  CarryOut   out  1          final OverflowOut; held with Result
//  AluA       out  8          to ALU InputA
//  AluB       out  8          to ALU InputB
//  AluOp      out  4          to ALU OP: 0000 add, 0001 sub, 1110 eql
//  AluOvIn    out  1          to ALU OverflowIn
//  AluOut     in   8          from ALU Out
//  AluOvOut   in   1          from ALU OverflowOut
// BEHAVIOUR
//  ALU contract: ADD {Ov,Out}=A+B+OvIn. SUB Out=(A-B-OvIn) mod 256 with Ov=1 iff A<B+OvIn.
//   EQL Out=1 iff A==B, else 0.
//  Reset (async): state IDLE; Busy, Done, Error, CarryOut = 0; Result = 0; idx = 0.
//   Operand and carry registers = 0.
//  IDLE: AluA/AluB/AluOp/AluOvIn = 0. On Start:
//   - Cmd=11: go to DONE. Error=1, Result=0, CarryOut=0.
//   - otherwise: latch OperandA, OperandB and Cmd; carry reg = CarryIn (0 for EQL).
//     Set the eq-accumulator to 1, idx=0, go to RUN.
//  RUN: drive AluA=A[8*idx+:8], AluB=B[8*idx+:8], AluOp per Cmd, AluOvIn=carry reg.
//   Each rising edge:
//   - ADD/SUB: Result[8*idx+:8]=AluOut; carry reg=AluOvOut.
//   - EQL: accumulator &= AluOut[0].
//   - idx++.
//   - On the edge capturing idx=NBYTES-1: go to DONE.
//     CarryOut = final carry (0 for EQL); EQL Result = {0..., accumulator}.
//  DONE: Done=1 for exactly one cycle, then IDLE. Start during DONE is ignored.
//  Latency: Done is visible after NBYTES+1 rising edges counted from and including the Start edge.
//   The reserved Cmd takes 1 edge.
//  Start in RUN or DONE is ignored; no queuing.
//   Operand inputs may change freely after the Start edge.
//  Reset mid-RUN aborts immediately: all outputs return to reset values.
//   The partial Result is discarded; the next Start runs normally.
//  NBYTES=1: RUN lasts one cycle.
//  Error clears on the next accepted Start.
// STRUCTURE
//  Shared package alu_defs:
//   - ALU opcode constants (OP_ADD=4'b0000, OP_SUB=4'b0001, OP_EQL=4'b1110).
//   - Cmd encodings.
//   - FSM state encoding {IDLE, RUN, DONE}.
//  No sub-module. The byte-select mux and capture logic stay inline; the ALU is instantiated by the parent.
// TESTING (NBYTES=4, real ALU attached)
//  ADD 0x000000FF+0x00000001, CarryIn=0 -> Result 0x00000100, CarryOut 0, Done 5th edge.
//  ADD 0xFFFFFFFF+0x00000001 -> Result 0x00000000, CarryOut 1.
//   SUB 0x00000100-0x00000001 -> 0x000000FF, CarryOut 0.
//  SUB 0x00000000-0x00000001 -> 0xFFFFFFFF, CarryOut 1.
//   SUB 5-3 with CarryIn=1 -> 0x00000001, CarryOut 0.
//  EQL 0x12345678 vs 0x12345678 -> Result 1.
//   EQL 0x12345678 vs 0x12345679 -> Result 0; CarryOut 0 in both cases.
//  Cmd=11 -> Done+Error next cycle. Start pulsed mid-RUN -> ignored, Result unchanged.
//  Reset after 2nd RUN edge -> all outputs 0 at once. A new ADD 1+1 then gives 0x00000002.

Source files
------------

// File: rtl/alu_defs.sv
// Shared definitions for the multi-byte ALU controller: ALU opcodes, commands, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_defs;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_EQL = 4'b1110;

    typedef enum logic [1:0] {
        CMD_ADD = 2'b00,
        CMD_SUB = 2'b01,
        CMD_EQL = 2'b10,
        CMD_RSV = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Map a wide-op command onto the byte-level ALU opcode.
    function automatic logic [3:0] cmd_to_op(input cmd_e c);
        case (c)
            CMD_SUB: cmd_to_op = OP_SUB;
            CMD_EQL: cmd_to_op = OP_EQL;
            default: cmd_to_op = OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multi_byte_alu_ctrl_if.sv
// Bundle between datapath control, the multi-byte ALU controller and the shared 8-bit ALU.
// Latency: n/a (wires only).
// Backpressure: none; Start is only honoured while the controller is idle.
interface multi_byte_alu_ctrl_if #(
    parameter int NBYTES = 4
);
    // request side
    logic                  Start;
    logic [1:0]            Cmd;
    logic                  CarryIn;
    logic [8*NBYTES-1:0]   OperandA;
    logic [8*NBYTES-1:0]   OperandB;
    // response side
    logic                  Busy;
    logic                  Done;
    logic                  Error;
    logic [8*NBYTES-1:0]   Result;
    logic                  CarryOut;
    // byte ALU side
    logic [7:0]            AluA;
    logic [7:0]            AluB;
    logic [3:0]            AluOp;
    logic                  AluOvIn;
    logic [7:0]            AluOut;
    logic                  AluOvOut;

    // datapath control issuing wide operations
    modport master (
        output Start, Cmd, CarryIn, OperandA, OperandB,
        input  Busy, Done, Error, Result, CarryOut
    );

    // the controller: serves requests and drives the byte ALU
    modport slave (
        input  Start, Cmd, CarryIn, OperandA, OperandB,
        output Busy, Done, Error, Result, CarryOut,
        output AluA, AluB, AluOp, AluOvIn,
        input  AluOut, AluOvOut
    );

    // the combinational byte ALU
    modport alu (
        input  AluA, AluB, AluOp, AluOvIn,
        output AluOut, AluOvOut
    );
endinterface

// File: rtl/multi_byte_alu_ctrl.sv
// Runs NBYTES-wide ADD/SUB/EQL on a shared 8-bit ALU, one byte per cycle, LSB first.
// Latency: Done NBYTES+1 edges after the Start edge (reserved Cmd: 1 edge).
// Backpressure: Start ignored outside IDLE (no queuing); Busy high while bytes are processed.
module multi_byte_alu_ctrl
    import alu_defs::*;
#(
    parameter int NBYTES = 4
) (
    input logic                  Clk,
    input logic                  Reset,
    multi_byte_alu_ctrl_if.slave bus
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    cmd_e            cmd_q, cmd_d;
    logic            carry_q, carry_d;
    logic            eq_q, eq_d;
    logic            carry_out_q, carry_out_d;
    logic            error_q, error_d;

    cmd_e            cmd_in;
    logic [W-1:0]    a_shift;
    logic [W-1:0]    b_shift;

    // State and datapath registers; a reset anywhere (including mid-RUN) discards the operation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            cmd_q       <= CMD_ADD;
            carry_q     <= 1'b0;
            eq_q        <= 1'b0;
            carry_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            cmd_q       <= cmd_d;
            carry_q     <= carry_d;
            eq_q        <= eq_d;
            carry_out_q <= carry_out_d;
            error_q     <= error_d;
        end
    end

    // Next-state, byte-select mux and per-byte capture of the ALU result.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        cmd_d       = cmd_q;
        carry_d     = carry_q;
        eq_d        = eq_q;
        carry_out_d = carry_out_q;
        error_d     = error_q;

        cmd_in      = cmd_e'(bus.Cmd);
        a_shift     = a_q >> {idx_q, 3'b000};
        b_shift     = b_q >> {idx_q, 3'b000};

        bus.AluA    = 8'h00;
        bus.AluB    = 8'h00;
        bus.AluOp   = 4'b0000;
        bus.AluOvIn = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    if (cmd_in == CMD_RSV) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        error_d = 1'b0;
                        a_d     = bus.OperandA;
                        b_d     = bus.OperandB;
                        cmd_d   = cmd_in;
                        // EQL never chains a carry, so the incoming one is dropped
                        carry_d = (cmd_in == CMD_EQL) ? 1'b0 : bus.CarryIn;
                        eq_d    = 1'b1;
                        idx_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                bus.AluA    = a_shift[7:0];
                bus.AluB    = b_shift[7:0];
                bus.AluOp   = cmd_to_op(cmd_q);
                bus.AluOvIn = carry_q;

                if (cmd_q == CMD_EQL) begin
                    eq_d = eq_q & bus.AluOut[0];
                end else begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_q == IW'(i)) begin
                            result_d[8*i +: 8] = bus.AluOut;
                        end
                    end
                    carry_d = bus.AluOvOut;
                end
                idx_d = idx_q + IW'(1);

                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    if (cmd_q == CMD_EQL) begin
                        result_d    = {{(W-1){1'b0}}, eq_q & bus.AluOut[0]};
                        carry_out_d = 1'b0;
                    end else begin
                        carry_out_d = bus.AluOvOut;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.Busy     = (state_q == ST_RUN);
    assign bus.Done     = (state_q == ST_DONE);
    assign bus.Error    = error_q;
    assign bus.Result   = result_q;
    assign bus.CarryOut = carry_out_q;

endmodule

// File: tb/tb_multi_byte_alu_ctrl.sv
// Bench for the multi-byte ALU controller with a behavioural byte ALU attached.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_byte_alu_ctrl;
    import alu_defs::*;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic clk = 1'b0;
    logic rst;

    multi_byte_alu_ctrl_if #(.NBYTES(NBYTES)) bus ();

    multi_byte_alu_ctrl #(.NBYTES(NBYTES)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte ALU as described by its contract.
    logic [8:0] alu_t;
    always_comb begin
        alu_t        = 9'd0;
        bus.AluOut   = 8'h00;
        bus.AluOvOut = 1'b0;
        case (bus.AluOp)
            4'b0000: begin
                alu_t        = {1'b0, bus.AluA} + {1'b0, bus.AluB} + {8'd0, bus.AluOvIn};
                bus.AluOut   = alu_t[7:0];
                bus.AluOvOut = alu_t[8];
            end
            4'b0001: begin
                bus.AluOut   = bus.AluA - bus.AluB - {7'd0, bus.AluOvIn};
                bus.AluOvOut = ({1'b0, bus.AluA} < ({1'b0, bus.AluB} + {8'd0, bus.AluOvIn}));
            end
            4'b1110: begin
                bus.AluOut   = {7'd0, (bus.AluA == bus.AluB)};
            end
            default: begin
                bus.AluOut   = 8'h00;
            end
        endcase
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: timeline of the current operation plus its arithmetic outcome.
    int             m_run_first, m_run_last, m_done_edge, m_hold_from;
    logic [W-1:0]   m_a, m_b, m_res;
    logic [1:0]     m_cmd;
    logic           m_cin, m_co, m_err;
    bit             mon_en = 1'b0;

    task automatic model_reset();
        m_run_first = 1;
        m_run_last  = 0;
        m_done_edge = -1;
        m_hold_from = 0;
        m_a = '0; m_b = '0; m_res = '0;
        m_cmd = 2'b00; m_cin = 1'b0; m_co = 1'b0; m_err = 1'b0;
    endtask

    // Checks every cycle against the model.
    int           k;
    logic [63:0]  mask, sa, sb, exp_ov, exp_op;
    logic         exp_busy;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                exp_busy = (edge_cnt >= m_run_first) && (edge_cnt <= m_run_last);
                chk("busy", bus.Busy, exp_busy);
                chk("done", bus.Done, edge_cnt == m_done_edge);
                if (edge_cnt >= m_hold_from) begin
                    chk("result", bus.Result, m_res);
                    chk("carry_out", bus.CarryOut, m_co);
                    chk("error", bus.Error, m_err);
                end
                if (exp_busy) begin
                    k    = edge_cnt - m_run_first;
                    mask = (64'd1 << (8 * k)) - 64'd1;
                    sa   = {32'd0, m_a} & mask;
                    sb   = {32'd0, m_b} & mask;
                    case (m_cmd)
                        2'b00: begin
                            exp_op = 64'h0;
                            exp_ov = ((sa + sb + {63'd0, m_cin}) >> (8 * k)) & 64'd1;
                        end
                        2'b01: begin
                            exp_op = 64'h1;
                            exp_ov = (sa < (sb + {63'd0, m_cin})) ? 64'd1 : 64'd0;
                        end
                        default: begin
                            exp_op = 64'he;
                            exp_ov = 64'd0;
                        end
                    endcase
                    chk("alu_a", bus.AluA, ({32'd0, m_a} >> (8 * k)) & 64'hFF);
                    chk("alu_b", bus.AluB, ({32'd0, m_b} >> (8 * k)) & 64'hFF);
                    chk("alu_op", bus.AluOp, exp_op);
                    chk("alu_ovin", bus.AluOvIn, exp_ov);
                end else begin
                    chk("alu_idle", {bus.AluA, bus.AluB, bus.AluOp, bus.AluOvIn}, 64'd0);
                end
            end
        end
    end

    // Drive a Start on a falling edge and record what the model expects of it.
    task automatic start_op(input logic [1:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin);
        logic [W:0] s;
        int         e;
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Cmd      = cmd;
        bus.OperandA = a;
        bus.OperandB = b;
        bus.CarryIn  = cin;
        e = edge_cnt;
        m_a = a; m_b = b; m_cmd = cmd;
        m_cin = (cmd == 2'b10) ? 1'b0 : cin;
        if (cmd == 2'b11) begin
            m_run_first = 1; m_run_last = 0;
            m_done_edge = e + 1; m_hold_from = e + 1;
            m_res = '0; m_co = 1'b0; m_err = 1'b1;
        end else begin
            m_run_first = e + 1; m_run_last = e + NBYTES;
            m_done_edge = e + NBYTES + 1; m_hold_from = e + NBYTES + 1;
            m_err = 1'b0;
            case (cmd)
                2'b00: begin
                    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    m_res = s[W-1:0]; m_co = s[W];
                end
                2'b01: begin
                    m_res = a - b - {{(W-1){1'b0}}, cin};
                    m_co  = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, cin}));
                end
                default: begin
                    m_res = (a == b) ? 1 : 0; m_co = 1'b0;
                end
            endcase
        end
    endtask

    // inj: 0 none, 1 Start pulse mid-RUN, 2 Start pulse while Done is shown.
    task automatic do_op(input string name, input logic [1:0] cmd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic [W-1:0] exp_res,
                         input logic exp_co, input int inj);
        int lat;
        lat = (cmd == 2'b11) ? 1 : NBYTES + 1;
        start_op(cmd, a, b, cin);
        @(negedge clk);
        bus.Start    = 1'b0;
        bus.OperandA = ~a;
        bus.OperandB = a ^ b ^ 32'h5A5A5A5A;
        bus.CarryIn  = ~cin;
        for (int i = 1; i < lat; i++) begin
            if (inj == 1 && i == 2) begin
                bus.Start = 1'b1;
                bus.Cmd   = 2'b01;
            end else begin
                bus.Start = 1'b0;
                bus.Cmd   = cmd;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
        #2;
        chk({name, "_done"}, bus.Done, 1'b1);
        chk({name, "_res"}, bus.Result, exp_res);
        chk({name, "_co"}, bus.CarryOut, exp_co);
        chk({name, "_err"}, bus.Error, cmd == 2'b11);
        if (inj == 2) begin
            bus.Start = 1'b1;
            bus.Cmd   = 2'b00;
        end
        @(negedge clk);
        bus.Start = 1'b0;
        #2;
        chk({name, "_idle"}, bus.Done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.Start    = 1'b0;
        bus.Cmd      = 2'b00;
        bus.CarryIn  = 1'b0;
        bus.OperandA = '0;
        bus.OperandB = '0;
        model_reset();
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_done", bus.Done, 1'b0);
        chk("rst_result", bus.Result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_ff_1",   2'b00, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 0);
        do_op("add_wrap",   2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 0);
        do_op("sub_100_1",  2'b01, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 0);
        do_op("sub_0_1",    2'b01, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 0);
        do_op("sub_5_3_b",  2'b01, 32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 1'b0, 0);
        do_op("eql_same",   2'b10, 32'h12345678, 32'h12345678, 1'b1, 32'h00000001, 1'b0, 0);
        do_op("eql_diff",   2'b10, 32'h12345678, 32'h12345679, 1'b0, 32'h00000000, 1'b0, 0);
        do_op("eql_hi",     2'b10, 32'h92345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 0);
        do_op("add_midrun", 2'b00, 32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1);
        do_op("rsv",        2'b11, 32'hDEADBEEF, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 0);
        do_op("add_in_done",2'b00, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, 2);

        // abort an ADD after its second RUN edge
        start_op(2'b00, 32'h11111111, 32'h22222222, 1'b0);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        chk("abort_busy", bus.Busy, 1'b0);
        chk("abort_result", bus.Result, 32'h0);
        chk("abort_alu_a", bus.AluA, 8'h00);
        chk("abort_co", bus.CarryOut, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        do_op("add_1_1",    2'b00, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 0);

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
